tdm_link_sched: RTL and testbench

Time-division scheduler for the shared 1-bit link formed by the 4:1 `mux_fd` and the 1:4 `demux`. It arbitrates round-robin among four word-wide requesters and drives the common `sel` to both mux and demux. It serializes the granted word LSB-first onto the selected mux input and deserializes the bits returned on the matching demux output. This is the block that sequences the mux/demux pair; the pair itself stays purely combinational.

---
 rtl/tdm_pkg.sv | 20 ++
 rtl/tdm_link_sched_rr_arb4.sv | 28 ++
 rtl/tdm_link_sched.sv | 127 ++++++++++++
 tb/tb_tdm_link_sched.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared types for the TDM link scheduler.
// Lane indices, FSM states and the one-hot lane helper.
package tdm_pkg;

  localparam int NLANES = 4;
  localparam int SELW   = 2;

  typedef logic [SELW-1:0] lane_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  function automatic logic [NLANES-1:0] lane_oh(lane_t l);
    lane_oh = 4'b0001 << l;
  endfunction

endpackage

// File: rtl/tdm_link_sched_rr_arb4.sv
// Round-robin arbiter over four lanes.
// Grants the first requesting lane at or after ptr, wrapping 3->0.
module rr_arb4
  import tdm_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] gnt_idx,
  output logic       any
);

  lane_t idx;

  // Scan from the farthest offset down so the nearest hit wins.
  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int i = NLANES - 1; i >= 0; i--) begin
      idx = ptr + lane_t'(i);
      if (req[idx]) begin
        gnt_idx = idx;
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tdm_link_sched.sv
// Time-division scheduler for a shared 1-bit mux/demux link.
// Serializes granted words LSB-first and rebuilds returned bits.
module tdm_link_sched
  import tdm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            req_valid,
  input  logic [4*WIDTH-1:0]    req_data,
  output logic [3:0]            req_ready,
  output logic [1:0]            sel,
  output logic [3:0]            mux_in,
  input  logic [3:0]            demux_out,
  output logic [4*WIDTH-1:0]    rx_data,
  output logic [3:0]            rx_valid,
  output logic                  busy,
  output logic                  link_err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t               state_q;
  state_t               state_d;
  lane_t                ptr_q;
  lane_t                sel_q;
  lane_t                gnt;
  logic                 any;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH-1:0]     shreg_q;
  logic [WIDTH-1:0]     rx_shreg_q;
  logic [WIDTH-1:0]     rx_next;
  logic [4*WIDTH-1:0]   rx_data_q;
  logic [3:0]           rx_valid_q;
  logic                 link_err_q;
  logic [3:0]           sel_oh;

  rr_arb4 u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt_idx (gnt),
    .any     (any)
  );

  assign sel_oh  = lane_oh(sel_q);
  assign rx_next = {demux_out[sel_q], rx_shreg_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any) state_d = SHIFT;
      SHIFT:   if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The last shifted bit is folded straight into rx_data so the
  // word and its rx_valid pulse are both visible during DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      sel_q      <= '0;
      cnt_q      <= '0;
      shreg_q    <= '0;
      rx_shreg_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= '0;
      link_err_q <= 1'b0;
    end else begin
      rx_valid_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (any) begin
            sel_q   <= gnt;
            shreg_q <= req_data[int'(gnt)*WIDTH +: WIDTH];
            cnt_q   <= '0;
          end
        end
        SHIFT: begin
          shreg_q    <= shreg_q >> 1;
          rx_shreg_q <= rx_next;
          cnt_q      <= cnt_q + 1'b1;
          if ((demux_out & ~sel_oh) != 4'b0000) begin
            link_err_q <= 1'b1;
          end
          if (cnt_q == LAST) begin
            rx_data_q[int'(sel_q)*WIDTH +: WIDTH] <= rx_next;
            rx_valid_q[sel_q] <= 1'b1;
          end
        end
        DONE: begin
          ptr_q <= sel_q + lane_t'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready = '0;
    mux_in    = '0;
    if (state_q == IDLE && any) begin
      req_ready = lane_oh(gnt);
    end
    if (state_q == SHIFT) begin
      mux_in = sel_oh & {4{shreg_q[0]}};
    end
  end

  assign sel      = sel_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = (state_q != IDLE);
  assign link_err = link_err_q;

endmodule

// File: tb/tb_tdm_link_sched.sv
// Directed bench for tdm_link_sched in mux/demux loopback.
// The 4:1 mux and 1:4 demux are modelled inline.
module tb_tdm_link_sched;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic [3:0]     req_valid;
  logic [4*W-1:0] req_data;
  logic [3:0]     req_ready;
  logic [1:0]     sel;
  logic [3:0]     mux_in;
  logic [3:0]     demux_out;
  logic [4*W-1:0] rx_data;
  logic [3:0]     rx_valid;
  logic           busy;
  logic           link_err;

  logic           mux_y;
  logic [3:0]     inj;
  int             checks;
  int             fails;
  int             cyc;
  int             acc_cyc;

  tdm_link_sched #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .sel       (sel),
    .mux_in    (mux_in),
    .demux_out (demux_out),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .busy      (busy),
    .link_err  (link_err)
  );

  assign mux_y     = mux_in[sel];
  assign demux_out = ((4'b0001 << sel) & {4{mux_y}}) | inj;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    inj       = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_accept(input logic [3:0] exp, input string tag);
    int n;
    n = 0;
    #1;
    while (req_ready == 4'b0000 && n < 30) begin
      @(negedge clk);
      #1;
      n++;
    end
    acc_cyc = cyc;
    chk({tag, "_rdy"}, {28'd0, req_ready}, {28'd0, exp});
  endtask

  task automatic finish_word(input int lane, input logic [7:0] d,
                             input string tag);
    logic [7:0] cap;
    int bad;
    cap = '0;
    bad = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i <= 9 && (sel !== 2'(lane) || busy !== 1'b1)) bad++;
      if (i <= 8) begin
        cap[i-1] = mux_in[lane];
        if ((mux_in & ~(4'b0001 << lane)) != 4'b0000) bad++;
      end
      if (i == 9) begin
        chk({tag, "_rxv"}, {28'd0, rx_valid}, 32'(4'b0001 << lane));
        chk({tag, "_rxd"}, {24'd0, rx_data[lane*W +: W]}, {24'd0, d});
        chk({tag, "_mux0"}, {28'd0, mux_in}, 32'd0);
      end
      if (i == 10) begin
        chk({tag, "_rxv_off"}, {28'd0, rx_valid}, 32'd0);
      end
    end
    chk({tag, "_tx"}, {24'd0, cap}, {24'd0, d});
    chk({tag, "_seq"}, bad, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    checks    = 0;
    fails     = 0;
    req_data  = '0;
    req_valid = '0;
    inj       = '0;
    do_reset();

    chk("rst_sel", {30'd0, sel}, 32'd0);
    chk("rst_mux", {28'd0, mux_in}, 32'd0);
    chk("rst_rdy", {28'd0, req_ready}, 32'd0);
    chk("rst_rxv", {28'd0, rx_valid}, 32'd0);
    chk("rst_rxd", rx_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, link_err}, 32'd0);

    // single request on lane 2
    req_data  = {8'h00, 8'hA5, 8'h00, 8'h00};
    req_valid = 4'b0100;
    wait_accept(4'b0100, "t1");
    @(posedge clk); #1;
    req_valid = '0;
    finish_word(2, 8'hA5, "t1");
    chk("t1_idle", {31'd0, busy}, 32'd0);
    chk("t1_err", {31'd0, link_err}, 32'd0);

    // round-robin with all lanes valid
    do_reset();
    req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    req_valid = 4'b1111;
    for (int l = 0; l < 4; l++) begin
      int prev;
      prev = acc_cyc;
      wait_accept(4'b0001 << l, "t2");
      if (l > 0) chk("t2_gap", acc_cyc - prev, 32'd10);
      @(posedge clk); #1;
      if (l == 3) req_valid = '0;
      finish_word(l, req_data[l*W +: W], "t2");
    end

    // pointer fairness: lane 1 then lanes 0 and 3 together
    req_data  = {8'h3C, 8'h00, 8'h5A, 8'hC3};
    req_valid = 4'b0010;
    wait_accept(4'b0010, "t3a");
    @(posedge clk); #1;
    req_valid = '0;
    finish_word(1, 8'h5A, "t3a");
    req_valid = 4'b1001;
    wait_accept(4'b1000, "t3b");
    @(posedge clk); #1;
    req_valid = 4'b0001;
    finish_word(3, 8'h3C, "t3b");
    wait_accept(4'b0001, "t3c");
    @(posedge clk); #1;
    req_valid = '0;
    finish_word(0, 8'hC3, "t3c");

    // wrap and edge data
    req_data  = {8'h80, 8'h3C, 8'h00, 8'h01};
    req_valid = 4'b1000;
    wait_accept(4'b1000, "t4a");
    @(posedge clk); #1;
    req_valid = '0;
    finish_word(3, 8'h80, "t4a");
    req_valid = 4'b0101;
    wait_accept(4'b0001, "t4b");
    @(posedge clk); #1;
    req_valid = 4'b0100;
    finish_word(0, 8'h01, "t4b");
    wait_accept(4'b0100, "t4c");
    @(posedge clk); #1;
    req_valid = '0;
    finish_word(2, 8'h3C, "t4c");

    // reset in the 4th shift cycle
    do_reset();
    req_data  = {8'h00, 8'h00, 8'hFF, 8'h00};
    req_valid = 4'b0010;
    wait_accept(4'b0010, "t5");
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_sel", {30'd0, sel}, 32'd0);
    chk("t5_mux", {28'd0, mux_in}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_rxd", rx_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (rx_valid != 4'b0000) seen++;
    end
    chk("t5_norxv", seen, 32'd0);
    chk("t5_rxd1", {24'd0, rx_data[1*W +: W]}, 32'd0);

    // fault injection on lane 0 while lane 2 shifts
    req_data  = {8'h0F, 8'h96, 8'h00, 8'h00};
    req_valid = 4'b0100;
    wait_accept(4'b0100, "t6");
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    inj = 4'b0001;
    chk("t6_pre", {31'd0, link_err}, 32'd0);
    @(posedge clk); #1;
    inj = '0;
    chk("t6_rise", {31'd0, link_err}, 32'd1);
    repeat (10) @(negedge clk);
    req_valid = 4'b1000;
    wait_accept(4'b1000, "t6b");
    @(posedge clk); #1;
    req_valid = '0;
    finish_word(3, 8'h0F, "t6b");
    chk("t6_sticky", {31'd0, link_err}, 32'd1);
    do_reset();
    chk("t6_clr", {31'd0, link_err}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
